// File: rtl/nx_grid_sequencer.sv
// ---------------------------------------------------------------------------
// nx_grid_sequencer
//
// Central controller for a grid of nx_node instances. Once every node reports
// idle it broadcasts a single-cycle trigger. It then passes the channel token
// to each node in index order, waits for the grid to settle again, and counts
// the completed cycle. A run stops after a programmed number of cycles
// (pulsing done_o), or at the next settle point after enable_i drops when the
// programmed count is zero.
//
// Parameters
//   NODES          number of nodes, indexed 0..NODES-1 (row-major flattening)
//   CYCLE_WIDTH    width of the cycle target and the cycle counter
//   SETTLE_CYCLES  consecutive all-idle cycles that mean "grid settled" (>=1)
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-low reset
//   enable_i         level-sensitive run request
//   cycles_i         cycles to run, 0 = run until enable_i drops
//   node_idle_i      per-node idle flags
//   token_release_i  per-node token release flags
//   trigger_o        one-cycle broadcast trigger
//   token_grant_o    one-hot-or-zero token grant
//   busy_o           high whenever the sequencer is not idle
//   done_o           one-cycle pulse when the programmed cycle count completes
//   cycle_count_o    completed cycles since the last run start
// ---------------------------------------------------------------------------
module nx_grid_sequencer #(
  parameter int NODES         = 16,
  parameter int CYCLE_WIDTH   = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic [CYCLE_WIDTH-1:0] cycles_i,
  input  logic [NODES-1:0]       node_idle_i,
  input  logic [NODES-1:0]       token_release_i,
  output logic                   trigger_o,
  output logic [NODES-1:0]       token_grant_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [CYCLE_WIDTH-1:0] cycle_count_o
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int IW = (NODES > 1) ? $clog2(NODES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_TRIGGER,
    ST_TOKEN,
    ST_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [SW-1:0]          settle_cnt_q, settle_cnt_d;
  logic                   first_q, first_d;
  logic [CYCLE_WIDTH-1:0] target_q, target_d;
  logic [CYCLE_WIDTH-1:0] count_d;
  logic [NODES-1:0]       grant_d;
  logic [IW-1:0]          idx_q, idx_d;

  // Next-state logic. Every registered output is derived from the next
  // state here and then captured in the register process, so outputs are
  // plain flops with no combinational path from any input.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    first_d      = first_q;
    target_d     = target_q;
    count_d      = cycle_count_o;
    grant_d      = token_grant_o;
    idx_d        = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d      = ST_SETTLE;
          target_d     = cycles_i;
          count_d      = '0;
          first_d      = 1'b1;
          settle_cnt_d = '0;
        end
      end

      ST_SETTLE: begin
        // The decision is taken on the edge on which the all-idle count
        // would reach SETTLE_CYCLES, so SETTLE lasts SETTLE_CYCLES cycles
        // when the grid is already quiet.
        if ((&node_idle_i) && (token_grant_o == '0)) begin
          if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
            settle_cnt_d = '0;
            if (first_q) begin
              first_d = 1'b0;
              state_d = ST_TRIGGER;
            end else begin
              count_d = cycle_count_o + CYCLE_WIDTH'(1);
              if ((target_q != '0) && (count_d == target_q)) begin
                state_d = ST_DONE;
              end else if (!enable_i) begin
                state_d = ST_IDLE;
              end else begin
                state_d = ST_TRIGGER;
              end
            end
          end else begin
            settle_cnt_d = settle_cnt_q + SW'(1);
          end
        end else begin
          settle_cnt_d = '0;
        end
      end

      ST_TRIGGER: begin
        state_d = ST_TOKEN;
        grant_d = NODES'(1);
        idx_d   = '0;
      end

      ST_TOKEN: begin
        // Only the release bit of the node currently holding the token is
        // looked at; everything else on token_release_i is ignored.
        if (token_release_i[idx_q]) begin
          if (idx_q == IW'(NODES - 1)) begin
            grant_d      = '0;
            state_d      = ST_SETTLE;
            settle_cnt_d = '0;
          end else begin
            grant_d = token_grant_o << 1;
            idx_d   = idx_q + IW'(1);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Reset withdraws the token and clears all
  // outputs immediately, without waiting for a clock edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= ST_IDLE;
      settle_cnt_q  <= '0;
      first_q       <= 1'b0;
      target_q      <= '0;
      idx_q         <= '0;
      cycle_count_o <= '0;
      token_grant_o <= '0;
      trigger_o     <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      first_q       <= first_d;
      target_q      <= target_d;
      idx_q         <= idx_d;
      cycle_count_o <= count_d;
      token_grant_o <= grant_d;
      trigger_o     <= (state_d == ST_TRIGGER);
      busy_o        <= (state_d != ST_IDLE);
      done_o        <= (state_d == ST_DONE);
    end
  end

endmodule
